// File: rtl/control_unit.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing with wait-counted
// memory reads and a two-source exception path (bad opcode, arithmetic overflow).
module control_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Overflow,
  input  logic       EQ,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ABWrite,
  output logic       ALUOutControl,
  output logic       MDRWrite,
  output logic       EPCWrite,
  output logic [2:0] ALU_Control,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] IorD,
  output logic [2:0] PCSource,
  output logic [2:0] RegDst,
  output logic [2:0] DataSrc,
  output logic [1:0] ExcpCtrl,
  output logic [4:0] State
);

  typedef enum logic [4:0] {
    S_FETCH      = 5'd0,
    S_DECODE     = 5'd1,
    S_R_EXEC     = 5'd2,
    S_R_WB       = 5'd3,
    S_ADDI_EXEC  = 5'd4,
    S_I_WB       = 5'd5,
    S_MEM_ADDR   = 5'd6,
    S_LW_READ    = 5'd7,
    S_LW_WB      = 5'd8,
    S_SW_WRITE   = 5'd9,
    S_BRANCH     = 5'd10,
    S_LUI        = 5'd11,
    S_JUMP       = 5'd12,
    S_EXC_OPCODE = 5'd13,
    S_EXC_OVF    = 5'd14,
    S_EXC_READ   = 5'd15,
    S_EXC_JUMP   = 5'd16
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [1:0] LAST_WAIT = 2'd2;

  state_t     state;
  state_t     next_state;
  logic [1:0] wait_cnt;
  logic       exc_ovf;

  function automatic logic funct_supported(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
  endfunction

  // exc_ovf remembers which exception is being serviced so ExcpCtrl holds through EXC_READ
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= 2'd0;
      exc_ovf  <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= (next_state != state) ? 2'd0 : wait_cnt + 2'd1;
      if (state == S_EXC_OPCODE)
        exc_ovf <= 1'b0;
      else if (state == S_EXC_OVF)
        exc_ovf <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     if (wait_cnt == LAST_WAIT) next_state = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_RTYPE:      next_state = funct_supported(FUNCT) ? S_R_EXEC : S_EXC_OPCODE;
          OP_ADDI:       next_state = S_ADDI_EXEC;
          OP_LW, OP_SW:  next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_LUI:        next_state = S_LUI;
          OP_J:          next_state = S_JUMP;
          default:       next_state = S_EXC_OPCODE;
        endcase
      end
      S_R_EXEC:    next_state = (!Overflow || FUNCT == FN_AND) ? S_R_WB : S_EXC_OVF;
      S_ADDI_EXEC: next_state = Overflow ? S_EXC_OVF : S_I_WB;
      S_MEM_ADDR:  next_state = (OPCODE == OP_SW) ? S_SW_WRITE : S_LW_READ;
      S_LW_READ:   if (wait_cnt == LAST_WAIT) next_state = S_LW_WB;
      S_EXC_OPCODE, S_EXC_OVF: next_state = S_EXC_READ;
      S_EXC_READ:  if (wait_cnt == LAST_WAIT) next_state = S_EXC_JUMP;
      default:     next_state = S_FETCH;
    endcase
  end

  // Branch and R-type outputs also look at EQ/FUNCT, which are stable for the instruction
  always_comb begin
    PCWrite       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ABWrite       = 1'b0;
    ALUOutControl = 1'b0;
    MDRWrite      = 1'b0;
    EPCWrite      = 1'b0;
    ALU_Control   = ALU_PASS;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    IorD          = 3'b000;
    PCSource      = 3'b000;
    RegDst        = 3'b000;
    DataSrc       = 3'b000;
    ExcpCtrl      = 2'b00;
    case (state)
      S_FETCH: begin
        ALUSrcB     = 2'b01;
        ALU_Control = ALU_ADD;
        PCWrite     = (wait_cnt == LAST_WAIT);
        IRWrite     = (wait_cnt == LAST_WAIT);
      end
      S_DECODE: begin
        ABWrite       = 1'b1;
        ALUSrcB       = 2'b11;
        ALU_Control   = ALU_ADD;
        ALUOutControl = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA       = 1'b1;
        ALUOutControl = 1'b1;
        case (FUNCT)
          FN_SUB:  ALU_Control = ALU_SUB;
          FN_AND:  ALU_Control = ALU_AND;
          default: ALU_Control = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 3'b001;
      end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_Control   = ALU_ADD;
        ALUOutControl = 1'b1;
      end
      S_I_WB:      RegWrite = 1'b1;
      S_LW_READ: begin
        IorD     = 3'b001;
        MDRWrite = (wait_cnt == LAST_WAIT);
      end
      S_LW_WB: begin
        RegWrite = 1'b1;
        DataSrc  = 3'b001;
      end
      S_SW_WRITE: begin
        IorD     = 3'b001;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_Control = ALU_SUB;
        PCSource    = 3'b001;
        PCWrite     = (OPCODE == OP_BEQ) ? EQ : !EQ;
      end
      S_LUI: begin
        RegWrite = 1'b1;
        DataSrc  = 3'b010;
      end
      S_JUMP: begin
        PCSource = 3'b010;
        PCWrite  = 1'b1;
      end
      S_EXC_OPCODE, S_EXC_OVF: begin
        ALUSrcB     = 2'b01;
        ALU_Control = ALU_SUB;
        EPCWrite    = 1'b1;
        ExcpCtrl    = (state == S_EXC_OVF) ? 2'b01 : 2'b00;
      end
      S_EXC_READ: begin
        IorD     = 3'b010;
        MDRWrite = (wait_cnt == LAST_WAIT);
        ExcpCtrl = exc_ovf ? 2'b01 : 2'b00;
      end
      S_EXC_JUMP: begin
        PCSource = 3'b011;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected output vectors are queued
// by the stimulus and popped/compared by an independent negedge monitor.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] OPCODE, FUNCT;
  logic       Overflow, EQ;
  logic       PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutControl, MDRWrite, EPCWrite;
  logic [2:0] ALU_Control;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] IorD, PCSource, RegDst, DataSrc;
  logic [1:0] ExcpCtrl;
  logic [4:0] State;

  control_unit dut (
    .clock(clock), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
    .Overflow(Overflow), .EQ(EQ),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ABWrite(ABWrite), .ALUOutControl(ALUOutControl), .MDRWrite(MDRWrite), .EPCWrite(EPCWrite),
    .ALU_Control(ALU_Control), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .PCSource(PCSource), .RegDst(RegDst), .DataSrc(DataSrc), .ExcpCtrl(ExcpCtrl),
    .State(State)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [32:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {State, PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutControl, MDRWrite, EPCWrite,
  //  ALU_Control, ALUSrcA, ALUSrcB, IorD, PCSource, RegDst, DataSrc, ExcpCtrl}
  logic [32:0] act;
  assign act = {State, PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutControl, MDRWrite,
                EPCWrite, ALU_Control, ALUSrcA, ALUSrcB, IorD, PCSource, RegDst, DataSrc, ExcpCtrl};

  function automatic logic [32:0] mk(input logic [4:0] st, input logic [7:0] we,
                                     input logic [2:0] alu, input logic srca, input logic [1:0] srcb,
                                     input logic [2:0] iord, input logic [2:0] pcs,
                                     input logic [2:0] rdst, input logic [2:0] dsrc,
                                     input logic [1:0] excp);
    return {st, we, alu, srca, srcb, iord, pcs, rdst, dsrc, excp};
  endfunction

  // Hand-derived per-state vectors (write enables listed PC,Mem,IR,Reg,AB,ALUOut,MDR,EPC)
  logic [32:0] V_F0, V_F2, V_DEC, V_RADD, V_RSUB, V_RAND, V_RWB, V_ADDI, V_IWB, V_MADDR;
  logic [32:0] V_LWR, V_LWR2, V_LWWB, V_SW, V_BRT, V_BRN, V_LUI, V_JMP, V_XOP, V_XOV;
  logic [32:0] V_XRD_OP, V_XRD2_OP, V_XRD_OV, V_XRD2_OV, V_XJ;

  task automatic push(input string tag, input logic [32:0] v);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_fetch_dec(input string tag);
    push({tag, ":fetch0"}, V_F0);
    push({tag, ":fetch1"}, V_F0);
    push({tag, ":fetch2"}, V_F2);
    push({tag, ":decode"}, V_DEC);
  endtask

  task automatic push_exc_tail(input string tag, input logic ovf);
    push({tag, ":exc_read0"}, ovf ? V_XRD_OV  : V_XRD_OP);
    push({tag, ":exc_read1"}, ovf ? V_XRD_OV  : V_XRD_OP);
    push({tag, ":exc_read2"}, ovf ? V_XRD2_OV : V_XRD2_OP);
    push({tag, ":exc_jump"},  V_XJ);
  endtask

  // Called at posedge+1 of a FETCH cycle-0; runs for as many cycles as were queued.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic eq);
    int n;
    OPCODE   = op;
    FUNCT    = fn;
    Overflow = ovf;
    EQ       = eq;
    n = exp_q.size();
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [32:0] got, input logic [32:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (act !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.tag, act, e.v);
        end
      end
    end
  end

  initial begin : stimulus
    V_F0      = mk(5'd0,  8'h00, 3'b001, 1'b0, 2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_F2      = mk(5'd0,  8'hA0, 3'b001, 1'b0, 2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_DEC     = mk(5'd1,  8'h0C, 3'b001, 1'b0, 2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_RADD    = mk(5'd2,  8'h04, 3'b001, 1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_RSUB    = mk(5'd2,  8'h04, 3'b010, 1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_RAND    = mk(5'd2,  8'h04, 3'b011, 1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_RWB     = mk(5'd3,  8'h10, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0, 3'd1, 3'd0, 2'd0);
    V_ADDI    = mk(5'd4,  8'h04, 3'b001, 1'b1, 2'b10, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_IWB     = mk(5'd5,  8'h10, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_MADDR   = mk(5'd6,  8'h04, 3'b001, 1'b1, 2'b10, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_LWR     = mk(5'd7,  8'h00, 3'b000, 1'b0, 2'b00, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0);
    V_LWR2    = mk(5'd7,  8'h02, 3'b000, 1'b0, 2'b00, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0);
    V_LWWB    = mk(5'd8,  8'h10, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 3'd1, 2'd0);
    V_SW      = mk(5'd9,  8'h40, 3'b000, 1'b0, 2'b00, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0);
    V_BRT     = mk(5'd10, 8'h80, 3'b010, 1'b1, 2'b00, 3'd0, 3'd1, 3'd0, 3'd0, 2'd0);
    V_BRN     = mk(5'd10, 8'h00, 3'b010, 1'b1, 2'b00, 3'd0, 3'd1, 3'd0, 3'd0, 2'd0);
    V_LUI     = mk(5'd11, 8'h10, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 3'd2, 2'd0);
    V_JMP     = mk(5'd12, 8'h80, 3'b000, 1'b0, 2'b00, 3'd0, 3'd2, 3'd0, 3'd0, 2'd0);
    V_XOP     = mk(5'd13, 8'h01, 3'b010, 1'b0, 2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0);
    V_XOV     = mk(5'd14, 8'h01, 3'b010, 1'b0, 2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 2'd1);
    V_XRD_OP  = mk(5'd15, 8'h00, 3'b000, 1'b0, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0, 2'd0);
    V_XRD2_OP = mk(5'd15, 8'h02, 3'b000, 1'b0, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0, 2'd0);
    V_XRD_OV  = mk(5'd15, 8'h00, 3'b000, 1'b0, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0, 2'd1);
    V_XRD2_OV = mk(5'd15, 8'h02, 3'b000, 1'b0, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0, 2'd1);
    V_XJ      = mk(5'd16, 8'h80, 3'b000, 1'b0, 2'b00, 3'd0, 3'd3, 3'd0, 3'd0, 2'd0);

    reset = 1'b0; OPCODE = 6'h00; FUNCT = 6'h00; Overflow = 1'b0; EQ = 1'b0;
    push("reset_hold0", V_F0);
    push("reset_hold1", V_F0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    push_fetch_dec("add"); push("add:r_exec", V_RADD); push("add:r_wb", V_RWB);
    run(6'h00, 6'h20, 1'b0, 1'b0);

    push_fetch_dec("sub_ovf"); push("sub_ovf:r_exec", V_RSUB); push("sub_ovf:exc_ovf", V_XOV);
    push_exc_tail("sub_ovf", 1'b1);
    run(6'h00, 6'h22, 1'b1, 1'b0);

    push_fetch_dec("and_ovf"); push("and_ovf:r_exec", V_RAND); push("and_ovf:r_wb", V_RWB);
    run(6'h00, 6'h24, 1'b1, 1'b0);

    push_fetch_dec("bad_funct"); push("bad_funct:exc_op", V_XOP); push_exc_tail("bad_funct", 1'b0);
    run(6'h00, 6'h25, 1'b0, 1'b0);

    push_fetch_dec("lw"); push("lw:mem_addr", V_MADDR);
    push("lw:read0", V_LWR); push("lw:read1", V_LWR); push("lw:read2", V_LWR2);
    push("lw:wb", V_LWWB);
    run(6'h23, 6'h00, 1'b0, 1'b0);

    push_fetch_dec("sw"); push("sw:mem_addr", V_MADDR); push("sw:write", V_SW);
    run(6'h2B, 6'h00, 1'b0, 1'b0);

    push_fetch_dec("beq_t"); push("beq_t:branch", V_BRT); run(6'h04, 6'h00, 1'b0, 1'b1);
    push_fetch_dec("beq_n"); push("beq_n:branch", V_BRN); run(6'h04, 6'h00, 1'b0, 1'b0);
    push_fetch_dec("bne_t"); push("bne_t:branch", V_BRT); run(6'h05, 6'h00, 1'b0, 1'b0);
    push_fetch_dec("bne_n"); push("bne_n:branch", V_BRN); run(6'h05, 6'h00, 1'b0, 1'b1);

    push_fetch_dec("addi"); push("addi:exec", V_ADDI); push("addi:i_wb", V_IWB);
    run(6'h08, 6'h00, 1'b0, 1'b0);

    push_fetch_dec("addi_ovf"); push("addi_ovf:exec", V_ADDI); push("addi_ovf:exc_ovf", V_XOV);
    push_exc_tail("addi_ovf", 1'b1);
    run(6'h08, 6'h00, 1'b1, 1'b0);

    push_fetch_dec("lui"); push("lui:wb", V_LUI); run(6'h0F, 6'h00, 1'b0, 1'b0);
    push_fetch_dec("j");   push("j:jump", V_JMP); run(6'h02, 6'h00, 1'b0, 1'b0);

    push_fetch_dec("op3f"); push("op3f:exc_op", V_XOP); push_exc_tail("op3f", 1'b0);
    run(6'h3F, 6'h00, 1'b0, 1'b0);

    // lw aborted by reset during its second read cycle
    push_fetch_dec("lw_abort"); push("lw_abort:mem_addr", V_MADDR);
    push("lw_abort:read0", V_LWR); push("lw_abort:read1", V_LWR);
    OPCODE = 6'h23; FUNCT = 6'h00; Overflow = 1'b0; EQ = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_now("lw_abort:async_reset", act, V_F0);
    push("lw_abort:reset_hold0", V_F0);
    push("lw_abort:reset_hold1", V_F0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    push_fetch_dec("add_after_reset"); push("add_after_reset:r_exec", V_RADD);
    push("add_after_reset:r_wb", V_RWB);
    run(6'h00, 6'h20, 1'b0, 1'b0);

    repeat (2) @(posedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
